// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a per-grant
// hold timer, and a one-cycle timeout pulse when the timer revokes a grant.
module rr_arbiter8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  // "release" is a reserved word in SystemVerilog, so the port is named rel
  input  logic       rel,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [2:0]    hold_idx, hold_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    grant_n;
  logic          grant_valid_n;
  logic          timeout_n;
  logic [2:0]    idx;
  logic [2:0]    win;
  logic          found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_idx    <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_idx    <= hold_n;
      cnt         <= cnt_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
    end
  end

  // First requester at or after ptr, wrapping modulo 8
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    hold_n        = hold_idx;
    cnt_n         = cnt;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    case (state)
      IDLE: begin
        grant_n       = '0;
        grant_valid_n = 1'b0;
        if (found) begin
          state_n       = GRANT;
          hold_n        = win;
          cnt_n         = '0;
          grant_n       = 8'd1 << win;
          grant_valid_n = 1'b1;
        end
      end
      GRANT: begin
        if (rel || !req[hold_idx] || cnt == LAST) begin
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          cnt_n         = '0;
          ptr_n         = hold_idx + 3'd1;
          // Release or a dropped request outranks the timer as the exit cause
          timeout_n     = !rel && req[hold_idx];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n       = IDLE;
        grant_n       = '0;
        grant_valid_n = 1'b0;
      end
    endcase
  end

endmodule
